// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: MEM->WB bus layout,
// CP0 register addresses, exception codes and the exception vector.
package wb_pkg;

  localparam int MEM_WB_BUS_WIDTH = 156;
  localparam int EXC_BUS_WIDTH    = 33;

  // CP0 addresses are {rd[4:0], sel[2:0]}
  localparam logic [7:0] CP0_BADVADDR = 8'd64;
  localparam logic [7:0] CP0_COUNT    = 8'd72;
  localparam logic [7:0] CP0_STATUS   = 8'd96;
  localparam logic [7:0] CP0_CAUSE    = 8'd104;
  localparam logic [7:0] CP0_EPC      = 8'd112;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;

  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        brk;
    logic        eret;
    logic        adel;
    logic        ades;
    logic        tlbl;
    logic        tlbs;
    logic        mod;
    logic [31:0] badvaddr;
    logic [31:0] pc;
  } mem_wb_bus_t;

  // Highest-priority pending cause wins; 0 when nothing is raised.
  function automatic logic [4:0] exc_code_sel(input mem_wb_bus_t b);
    if (b.adel)         exc_code_sel = EXC_ADEL;
    else if (b.ades)    exc_code_sel = EXC_ADES;
    else if (b.tlbl)    exc_code_sel = EXC_TLBL;
    else if (b.tlbs)    exc_code_sel = EXC_TLBS;
    else if (b.mod)     exc_code_sel = EXC_MOD;
    else if (b.syscall) exc_code_sel = EXC_SYS;
    else if (b.brk)     exc_code_sel = EXC_BP;
    else                exc_code_sel = 5'd0;
  endfunction

endpackage

// File: rtl/wb_if.sv
// MEM->WB input bus and WB-stage outputs. Valid-only handshake: WB never
// stalls, so an asserted WB_valid is consumed on the same rising edge.
interface wb_if;
  import wb_pkg::*;

  logic                        WB_valid;
  logic [MEM_WB_BUS_WIDTH-1:0] MEM_WB_bus_r;
  logic                        rf_wen;
  logic [4:0]                  rf_wdest;
  logic [31:0]                 rf_wdata;
  logic                        WB_over;
  logic [4:0]                  WB_wdest;
  logic [EXC_BUS_WIDTH-1:0]    exc_bus;
  logic [31:0]                 WB_pc;

  modport master (
    output WB_valid, MEM_WB_bus_r,
    input  rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, exc_bus, WB_pc
  );

  modport slave (
    input  WB_valid, MEM_WB_bus_r,
    output rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, exc_bus, WB_pc
  );
endinterface

// File: rtl/wb_cp0_regs.sv
// CP0 register file: Status, Cause, EPC, BadVAddr, Count, and the state
// updates on exception entry, eret and mtc0.
module cp0_regs
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        exc,
  input  logic [4:0]  exc_code,
  input  logic        badv_we,
  input  logic [31:0] badvaddr,
  input  logic [31:0] pc,
  input  logic        eret,
  output logic [31:0] epc
);

  logic        status_exl;
  logic        status_ie;
  logic [4:0]  cause_code;
  logic [31:0] epc_r;
  logic [31:0] badvaddr_r;
  logic [31:0] count_r;
  logic        toggle;

  assign epc = epc_r;

  always_comb begin
    rdata = 32'd0;
    case (addr)
      CP0_BADVADDR: rdata = badvaddr_r;
      CP0_COUNT:    rdata = count_r;
      CP0_STATUS:   rdata = {9'd0, 1'b1, 20'd0, status_exl, status_ie};
      CP0_CAUSE:    rdata = {25'd0, cause_code, 2'd0};
      CP0_EPC:      rdata = epc_r;
      default:      rdata = 32'd0;
    endcase
  end

  // Count runs regardless of WB_valid; an mtc0 to Count overrides the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 32'd0;
      toggle  <= 1'b0;
    end else begin
      toggle <= ~toggle;
      if (we && addr == CP0_COUNT) count_r <= wdata;
      else if (toggle)             count_r <= count_r + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_exl <= STATUS_RESET[1];
      status_ie  <= STATUS_RESET[0];
      cause_code <= 5'd0;
      epc_r      <= 32'd0;
      badvaddr_r <= 32'd0;
    end else if (exc) begin
      cause_code <= exc_code;
      status_exl <= 1'b1;
      // Nested exceptions keep the EPC of the outermost one.
      if (!status_exl) epc_r <= pc;
      if (badv_we)     badvaddr_r <= badvaddr;
    end else begin
      if (we) begin
        case (addr)
          CP0_STATUS: {status_exl, status_ie} <= wdata[1:0];
          CP0_EPC:    epc_r <= wdata;
          default:    ;
        endcase
      end
      if (eret) status_exl <= 1'b0;
    end
  end

endmodule

// File: rtl/wb.sv
// Write-back stage: decodes the MEM->WB bus, owns HI/LO and the register
// file write mux, and raises pipeline flush/redirect via exc_bus.
module wb
  import wb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  wb_if.slave  bus
);

  mem_wb_bus_t b;
  logic        valid;
  logic        exc;
  logic        eret_take;
  logic        mtc0_we;
  logic        badv_we;
  logic [4:0]  exc_code;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] cp0_rdata;
  logic [31:0] epc;
  logic [31:0] wdata_mux;
  logic [32:0] exc_bus_raw;

  assign b         = bus.MEM_WB_bus_r;
  assign valid     = bus.WB_valid;
  assign exc       = valid & (b.adel | b.ades | b.tlbl | b.tlbs | b.mod | b.syscall | b.brk);
  assign eret_take = valid & b.eret & ~exc;
  assign mtc0_we   = valid & b.mtc0 & ~exc;
  assign badv_we   = b.adel | b.ades | b.tlbl | b.tlbs | b.mod;
  assign exc_code  = exc_code_sel(b);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (valid && !exc) begin
      if (b.hi_write) hi_r <= b.mem_result;
      if (b.lo_write) lo_r <= b.lo_result;
    end
  end

  cp0_regs u_cp0 (
    .clk      (clk),
    .reset    (reset),
    .addr     (b.cp0r_addr),
    .rdata    (cp0_rdata),
    .we       (mtc0_we),
    .wdata    (b.mem_result),
    .exc      (exc),
    .exc_code (exc_code),
    .badv_we  (badv_we),
    .badvaddr (b.badvaddr),
    .pc       (b.pc),
    .eret     (eret_take),
    .epc      (epc)
  );

  always_comb begin
    if (b.mfhi)      wdata_mux = hi_r;
    else if (b.mflo) wdata_mux = lo_r;
    else if (b.mfc0) wdata_mux = cp0_rdata;
    else             wdata_mux = b.mem_result;
  end

  always_comb begin
    if (exc)            exc_bus_raw = {1'b1, EXC_VECTOR};
    else if (eret_take) exc_bus_raw = {1'b1, epc};
    else                exc_bus_raw = 33'd0;
  end

  // Everything visible outside is forced quiet while reset is held.
  assign bus.rf_wen   = ~reset & valid & b.rf_wen & ~exc;
  assign bus.rf_wdest = reset ? 5'd0 : b.rf_wdest;
  assign bus.rf_wdata = reset ? 32'd0 : wdata_mux;
  assign bus.WB_over  = ~reset & valid;
  assign bus.WB_wdest = reset ? 5'd0 : (b.rf_wdest & {5{valid}});
  assign bus.exc_bus  = reset ? 33'd0 : exc_bus_raw;
  assign bus.WB_pc    = reset ? 32'd0 : b.pc;

endmodule

// File: tb/tb_wb.sv
// Directed bench for the write-back stage: each step drives one bus word,
// queues the expected outputs and checks them mid-cycle.
module tb_wb;
  import wb_pkg::*;

  localparam int W = 67; // {chk_wdata, rf_wen, rf_wdata[31:0], exc_bus[32:0]}

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [W-1:0] exp_q[$];
  mem_wb_bus_t  b;

  wb_if u_if ();

  wb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic mem_wb_bus_t bus_alu(input logic [4:0] d, input logic [31:0] r);
    bus_alu = '0;
    bus_alu.rf_wen     = 1'b1;
    bus_alu.rf_wdest   = d;
    bus_alu.mem_result = r;
  endfunction

  function automatic mem_wb_bus_t bus_mfc0(input logic [7:0] a);
    bus_mfc0 = '0;
    bus_mfc0.rf_wen    = 1'b1;
    bus_mfc0.rf_wdest  = 5'd2;
    bus_mfc0.mfc0      = 1'b1;
    bus_mfc0.cp0r_addr = a;
  endfunction

  function automatic mem_wb_bus_t bus_mtc0(input logic [7:0] a, input logic [31:0] d);
    bus_mtc0 = '0;
    bus_mtc0.mtc0       = 1'b1;
    bus_mtc0.cp0r_addr  = a;
    bus_mtc0.mem_result = d;
  endfunction

  // Drive one cycle, queue expectations, compare at the falling edge.
  task automatic step(input string tag, input mem_wb_bus_t sb, input logic v,
                      input logic chk_d, input logic e_wen, input logic [31:0] e_wdata,
                      input logic [32:0] e_exc);
    logic [W-1:0] e;
    u_if.WB_valid     = v;
    u_if.MEM_WB_bus_r = sb;
    exp_q.push_back({chk_d, e_wen, e_wdata, e_exc});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".rf_wen"}, {32'd0, u_if.rf_wen}, {32'd0, e[65]});
    if (e[66]) check({tag, ".rf_wdata"}, {1'b0, u_if.rf_wdata}, {1'b0, e[64:33]});
    check({tag, ".exc_bus"}, u_if.exc_bus, e[32:0]);
    check({tag, ".WB_over"}, {32'd0, u_if.WB_over}, {32'd0, v});
    check({tag, ".WB_wdest"}, {28'd0, u_if.WB_wdest}, {28'd0, (v ? sb.rf_wdest : 5'd0)});
    check({tag, ".WB_pc"}, {1'b0, u_if.WB_pc}, {1'b0, sb.pc});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input string tag);
    reset = 1'b1;
    b = bus_alu(5'd7, 32'h5555_AAAA);
    b.adel = 1'b1;
    b.pc   = 32'h1234_5678;
    u_if.WB_valid     = 1'b1;
    u_if.MEM_WB_bus_r = b;
    @(negedge clk);
    check({tag, ".rf_wen"},   {32'd0, u_if.rf_wen},   33'd0);
    check({tag, ".rf_wdata"}, {1'b0, u_if.rf_wdata},  33'd0);
    check({tag, ".exc_bus"},  u_if.exc_bus,           33'd0);
    check({tag, ".WB_over"},  {32'd0, u_if.WB_over},  33'd0);
    check({tag, ".WB_wdest"}, {28'd0, u_if.WB_wdest}, 33'd0);
    check({tag, ".WB_pc"},    {1'b0, u_if.WB_pc},     33'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [32:0] NO_EXC  = 33'd0;
  localparam logic [32:0] VEC_EXC = {1'b1, 32'hBFC0_0380};

  initial begin
    reset = 1'b1;
    u_if.WB_valid     = 1'b0;
    u_if.MEM_WB_bus_r = '0;
    @(posedge clk);
    #1;
    reset_cycle("rst0");

    step("addu", bus_alu(5'd5, 32'h0000_1234), 1'b1, 1'b1, 1'b1, 32'h0000_1234, NO_EXC);

    b = '0; b.hi_write = 1'b1; b.lo_write = 1'b1;
    b.mem_result = 32'hA; b.lo_result = 32'hB;
    step("mult", b, 1'b1, 1'b1, 1'b0, 32'hA, NO_EXC);

    b = bus_alu(5'd3, 32'hFFFF_0000); b.mfhi = 1'b1;
    step("mfhi", b, 1'b1, 1'b1, 1'b1, 32'hA, NO_EXC);
    b = bus_alu(5'd4, 32'hFFFF_0000); b.mflo = 1'b1;
    step("mflo", b, 1'b1, 1'b1, 1'b1, 32'hB, NO_EXC);

    // Invalid slot carrying junk must not touch HI or raise anything.
    b = bus_alu(5'd9, 32'hDEAD_BEEF); b.hi_write = 1'b1; b.syscall = 1'b1; b.eret = 1'b1;
    step("idle", b, 1'b0, 1'b0, 1'b0, 32'd0, NO_EXC);
    b = bus_alu(5'd3, 32'h0); b.mfhi = 1'b1;
    step("mfhi2", b, 1'b1, 1'b1, 1'b1, 32'hA, NO_EXC);

    b = bus_alu(5'd8, 32'h0); b.adel = 1'b1;
    b.badvaddr = 32'h0000_1003; b.pc = 32'hBFC0_0100;
    step("adel", b, 1'b1, 1'b0, 1'b0, 32'd0, VEC_EXC);
    step("epc1",  bus_mfc0(CP0_EPC),      1'b1, 1'b1, 1'b1, 32'hBFC0_0100, NO_EXC);
    step("cause1", bus_mfc0(CP0_CAUSE),   1'b1, 1'b1, 1'b1, 32'h0000_0010, NO_EXC);
    step("badv1", bus_mfc0(CP0_BADVADDR), 1'b1, 1'b1, 1'b1, 32'h0000_1003, NO_EXC);
    step("stat1", bus_mfc0(CP0_STATUS),   1'b1, 1'b1, 1'b1, 32'h0040_0002, NO_EXC);

    b = '0; b.syscall = 1'b1; b.pc = 32'h0000_2000; b.badvaddr = 32'h7777_7777;
    step("sys", b, 1'b1, 1'b0, 1'b0, 32'd0, VEC_EXC);
    step("epc2",  bus_mfc0(CP0_EPC),      1'b1, 1'b1, 1'b1, 32'hBFC0_0100, NO_EXC);
    step("cause2", bus_mfc0(CP0_CAUSE),   1'b1, 1'b1, 1'b1, 32'h0000_0020, NO_EXC);
    step("badv2", bus_mfc0(CP0_BADVADDR), 1'b1, 1'b1, 1'b1, 32'h0000_1003, NO_EXC);

    b = '0; b.brk = 1'b1; b.pc = 32'h0000_2004;
    step("brk", b, 1'b1, 1'b0, 1'b0, 32'd0, VEC_EXC);
    step("cause3", bus_mfc0(CP0_CAUSE), 1'b1, 1'b1, 1'b1, 32'h0000_0024, NO_EXC);
    b = '0; b.brk = 1'b1; b.syscall = 1'b1; b.pc = 32'h0000_2008;
    step("sysbrk", b, 1'b1, 1'b0, 1'b0, 32'd0, VEC_EXC);
    step("cause4", bus_mfc0(CP0_CAUSE), 1'b1, 1'b1, 1'b1, 32'h0000_0020, NO_EXC);

    step("mtc0_epc", bus_mtc0(CP0_EPC, 32'h8000_0040), 1'b1, 1'b0, 1'b0, 32'd0, NO_EXC);
    b = '0; b.eret = 1'b1; b.pc = 32'h0000_3000;
    step("eret", b, 1'b1, 1'b0, 1'b0, 32'd0, {1'b1, 32'h8000_0040});
    step("stat2", bus_mfc0(CP0_STATUS), 1'b1, 1'b1, 1'b1, 32'h0040_0000, NO_EXC);

    step("mtc0_st", bus_mtc0(CP0_STATUS, 32'hFFFF_FFFF), 1'b1, 1'b0, 1'b0, 32'd0, NO_EXC);
    step("stat3", bus_mfc0(CP0_STATUS), 1'b1, 1'b1, 1'b1, 32'h0040_0003, NO_EXC);
    step("mtc0_ca", bus_mtc0(CP0_CAUSE, 32'hFFFF_FFFF), 1'b1, 1'b0, 1'b0, 32'd0, NO_EXC);
    step("cause5", bus_mfc0(CP0_CAUSE), 1'b1, 1'b1, 1'b1, 32'h0000_0020, NO_EXC);
    step("unlisted", bus_mfc0(8'd8), 1'b1, 1'b1, 1'b1, 32'd0, NO_EXC);

    // Count after reset: floor(edges_since_reset / 2).
    reset_cycle("rst1");
    step("cnt_e0",  bus_mfc0(CP0_COUNT),  1'b1, 1'b1, 1'b1, 32'd0, NO_EXC);
    step("stat_e1", bus_mfc0(CP0_STATUS), 1'b1, 1'b1, 1'b1, 32'h0040_0000, NO_EXC);
    for (int i = 0; i < 4; i++) step("idle_c", '0, 1'b0, 1'b0, 1'b0, 32'd0, NO_EXC);
    step("cnt_e6", bus_mfc0(CP0_COUNT), 1'b1, 1'b1, 1'b1, 32'd3, NO_EXC);
    step("cnt_e7", bus_mfc0(CP0_COUNT), 1'b1, 1'b1, 1'b1, 32'd3, NO_EXC);
    step("epc_e8", bus_mfc0(CP0_EPC),   1'b1, 1'b1, 1'b1, 32'd0, NO_EXC);
    step("mtc0_cnt", bus_mtc0(CP0_COUNT, 32'h100), 1'b1, 1'b0, 1'b0, 32'd0, NO_EXC);
    step("cnt_e10", bus_mfc0(CP0_COUNT), 1'b1, 1'b1, 1'b1, 32'h100, NO_EXC);
    step("cause_e11", bus_mfc0(CP0_CAUSE), 1'b1, 1'b1, 1'b1, 32'd0, NO_EXC);
    step("cnt_e12", bus_mfc0(CP0_COUNT), 1'b1, 1'b1, 1'b1, 32'h101, NO_EXC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
